// File: rtl/mem_access_sequencer_pkg.sv
// Shared constants and state type for the LDUR/STUR memory access sequencer.
package mem_access_sequencer_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StDecode,
    StAddr,
    StMem,
    StWb,
    StDone
  } state_e;

  localparam logic [10:0] OP_LDUR = 11'h7C2;
  localparam logic [10:0] OP_STUR = 11'h7C0;

  localparam logic [4:0] FS_ZERO_C = 5'b00000;
  localparam logic [4:0] FS_ADD_C  = 5'b01000;

  localparam logic [4:0] XZR = 5'd31;

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts memory wait cycles; expired flags the last allowed cycle without an acknowledge.
module mem_timeout_counter (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear_i,
  input  logic       enable_i,
  input  logic [7:0] timeout_i,
  output logic       expired_o
);

  logic [7:0] count_q;

  assign expired_o = (count_q == timeout_i - 8'd1);

  always_ff @(posedge clock) begin
    if (reset || clear_i) begin
      count_q <= 8'd0;
    end else if (enable_i && !expired_o) begin
      count_q <= count_q + 8'd1;
    end
  end

endmodule

// File: rtl/mem_access_sequencer.sv
// Multi-cycle LDUR/STUR sequencer driving register-file selects, ALU selects and the
// data-memory handshake. Outputs are registered from the next state and next latched IR.
module mem_access_sequencer
  import mem_access_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned TIMEOUT = 15,
  parameter logic [4:0]  FS_ADD  = FS_ADD_C
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       IR,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic [4:0]        SA,
  output logic [4:0]        SB,
  output logic [4:0]        DA,
  output logic              reg_write,
  output logic              b_sel,
  output logic [DATA_W-1:0] k,
  output logic [4:0]        alu_fs,
  output logic              addr_latch,
  output logic              mem_read,
  output logic              mem_write,
  output logic              wb_sel
);

  state_e      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic        fault_q, fault_d;
  logic        expired;
  logic        load_d;
  logic        unused_ir;

  assign unused_ir = ^ir_q[11:10];
  assign load_d    = (ir_d[31:21] == OP_LDUR);

  mem_timeout_counter u_timeout (
    .clock     (clock),
    .reset     (reset),
    .clear_i   (state_q != StMem),
    .enable_i  ((state_q == StMem) && !mem_ready),
    .timeout_i (8'(TIMEOUT)),
    .expired_o (expired)
  );

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    fault_d = fault_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          ir_d    = IR;
          fault_d = 1'b0;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (ir_q[31:21] == OP_LDUR || ir_q[31:21] == OP_STUR) begin
          state_d = StAddr;
        end else begin
          fault_d = 1'b1;
          state_d = StDone;
        end
      end
      StAddr: state_d = StMem;
      StMem: begin
        // An acknowledge on the expiring cycle still completes the access.
        if (mem_ready) begin
          state_d = (ir_q[31:21] == OP_LDUR) ? StWb : StDone;
        end else if (expired) begin
          fault_d = 1'b1;
          state_d = StDone;
        end
      end
      StWb: state_d = StDone;
      StDone: begin
        fault_d = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      ir_q       <= 32'd0;
      fault_q    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fault      <= 1'b0;
      SA         <= 5'd0;
      SB         <= 5'd0;
      DA         <= 5'd0;
      reg_write  <= 1'b0;
      b_sel      <= 1'b0;
      k          <= '0;
      alu_fs     <= FS_ZERO_C;
      addr_latch <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      wb_sel     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      fault_q    <= fault_d;
      busy       <= (state_d == StDecode) || (state_d == StAddr) ||
                    (state_d == StMem) || (state_d == StWb);
      done       <= (state_d == StDone);
      fault      <= (state_d == StDone) && fault_d;
      SA         <= 5'd0;
      SB         <= 5'd0;
      DA         <= 5'd0;
      reg_write  <= 1'b0;
      b_sel      <= 1'b0;
      k          <= '0;
      alu_fs     <= FS_ZERO_C;
      addr_latch <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      wb_sel     <= 1'b0;
      unique case (state_d)
        StAddr: begin
          SA         <= ir_d[9:5];
          k          <= {{(DATA_W - 9){ir_d[20]}}, ir_d[20:12]};
          b_sel      <= 1'b1;
          alu_fs     <= FS_ADD;
          addr_latch <= 1'b1;
        end
        StMem: begin
          mem_read  <= load_d;
          mem_write <= !load_d;
          SB        <= load_d ? 5'd0 : ir_d[4:0];
        end
        StWb: begin
          DA        <= ir_d[4:0];
          wb_sel    <= 1'b1;
          reg_write <= (ir_d[4:0] != XZR);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Randomized self-checking bench: per-cycle output vectors against a timeline model.
module tb_mem_access_sequencer;

  localparam int unsigned DATA_W  = 64;
  localparam int unsigned TIMEOUT = 15;
  localparam logic [4:0]  FS_ADD  = 5'b01000;
  localparam int          VW      = 93;

  logic              clock;
  logic              reset;
  logic              start;
  logic [31:0]       IR;
  logic              mem_ready;
  logic              busy, done, fault, reg_write, b_sel, addr_latch;
  logic              mem_read, mem_write, wb_sel;
  logic [4:0]        SA, SB, DA, alu_fs;
  logic [DATA_W-1:0] k;
  logic [VW-1:0]     act;

  int checks = 0;
  int errors = 0;

  mem_access_sequencer #(
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT),
    .FS_ADD  (FS_ADD)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .IR         (IR),
    .mem_ready  (mem_ready),
    .busy       (busy),
    .done       (done),
    .fault      (fault),
    .SA         (SA),
    .SB         (SB),
    .DA         (DA),
    .reg_write  (reg_write),
    .b_sel      (b_sel),
    .k          (k),
    .alu_fs     (alu_fs),
    .addr_latch (addr_latch),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .wb_sel     (wb_sel)
  );

  assign act = {busy, done, fault, SA, SB, DA, reg_write, b_sel, k, alu_fs,
                addr_latch, mem_read, mem_write, wb_sel};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] mk(input logic [10:0] op, input logic [8:0] imm,
                                     input logic [4:0] rn, input logic [4:0] rt);
    return {op, imm, 2'b00, rn, rt};
  endfunction

  function automatic bit is_legal(input logic [31:0] ir);
    return (ir[31:21] == 11'h7C2) || (ir[31:21] == 11'h7C0);
  endfunction

  // Wait < 0 means memory never acknowledges.
  function automatic bit times_out(input int w);
    return (w < 0) || (w > int'(TIMEOUT) - 1);
  endfunction

  function automatic int mem_len(input int w);
    return times_out(w) ? int'(TIMEOUT) : w + 1;
  endfunction

  function automatic int done_cycle(input logic [31:0] ir, input int w);
    bit ld;
    ld = (ir[31:21] == 11'h7C2);
    if (!is_legal(ir)) return 2;
    return 3 + mem_len(w) + ((ld && !times_out(w)) ? 1 : 0);
  endfunction

  // Expected outputs c cycles after the start cycle.
  function automatic logic [VW-1:0] exp_vec(input logic [31:0] ir, input int w, input int c);
    logic bz, dn, ft, rw, bs, al, mr, mw, wb;
    logic [4:0] sa, sb, da, fs;
    logic [DATA_W-1:0] kk;
    bit ld, to;
    int m, dc;
    {bz, dn, ft, rw, bs, al, mr, mw, wb} = '0;
    sa = '0; sb = '0; da = '0; fs = '0; kk = '0;
    ld = (ir[31:21] == 11'h7C2);
    to = times_out(w);
    m  = mem_len(w);
    dc = done_cycle(ir, w);
    if (c >= 1 && c < dc) bz = 1'b1;
    if (c == dc) begin
      dn = 1'b1;
      ft = !is_legal(ir) || to;
    end
    if (is_legal(ir)) begin
      if (c == 2) begin
        sa = ir[9:5];
        kk = DATA_W'($signed(ir[20:12]));
        bs = 1'b1;
        fs = FS_ADD;
        al = 1'b1;
      end
      if (c >= 3 && c < 3 + m) begin
        if (ld) mr = 1'b1;
        else begin
          mw = 1'b1;
          sb = ir[4:0];
        end
      end
      if (ld && !to && c == 3 + m) begin
        da = ir[4:0];
        wb = 1'b1;
        rw = (ir[4:0] != 5'd31);
      end
    end
    return {bz, dn, ft, sa, sb, da, rw, bs, kk, fs, al, mr, mw, wb};
  endfunction

  task automatic run_op(input logic [31:0] ir, input int w, input bit spam, input string name);
    int dc, m;
    logic [VW-1:0] expv;
    dc = done_cycle(ir, w);
    m  = is_legal(ir) ? mem_len(w) : 0;
    for (int c = 0; c <= dc + 1; c++) begin
      @(negedge clock);
      expv = exp_vec(ir, w, c);
      checks++;
      if (act !== expv) begin
        errors++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, c, act, expv);
      end
      IR    = (c == 0) ? ir : 32'($urandom);
      start = (c == 0) || (c <= dc && spam && ($urandom_range(1) == 1));
      if (c >= 3 && c < 3 + m) mem_ready = (c - 3 == w);
      else mem_ready = 1'($urandom_range(1));
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; mem_ready = 1'b1; IR = 32'hF84080A3;
    repeat (2) @(negedge clock);
    checks++;
    if (act !== '0) begin
      errors++;
      $display("FAIL reset: got %h expected 0", act);
    end
    reset = 1'b0; start = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic test_directed();
    run_op(32'hF84080A3, 0, 1'b0, "ldur_x3_x5_8");
    run_op(mk(11'h7C0, 9'h1FC, 5'd2, 5'd7), 3, 1'b0, "stur_x7_x2_m4");
    run_op(mk(11'h7C2, 9'h010, 5'd4, 5'd31), 1, 1'b0, "ldur_xzr");
    run_op(mk(11'h7C2, 9'h003, 5'd1, 5'd9), -1, 1'b0, "ldur_timeout");
    run_op(mk(11'h7C0, 9'h100, 5'd6, 5'd8), int'(TIMEOUT) - 1, 1'b0, "stur_ready_at_limit");
    run_op(mk(11'h458, 9'h0AA, 5'd3, 5'd4), 0, 1'b1, "illegal_spam");
    run_op(mk(11'h7C0, 9'h055, 5'd10, 5'd11), 2, 1'b1, "stur_spam");
  endtask

  task automatic test_reset_mid_mem();
    logic [31:0] ir;
    logic [VW-1:0] expv;
    ir = mk(11'h7C2, 9'h020, 5'd12, 5'd13);
    for (int c = 0; c <= 5; c++) begin
      @(negedge clock);
      expv = exp_vec(ir, -1, c);
      checks++;
      if (act !== expv) begin
        errors++;
        $display("FAIL reset_mid pre cycle %0d: got %h expected %h", c, act, expv);
      end
      IR = ir; start = (c == 0); mem_ready = 1'b0;
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (act !== '0) begin
        errors++;
        $display("FAIL reset_mid post cycle %0d: got %h expected 0", c, act);
      end
      @(negedge clock);
    end
    run_op(32'hF84080A3, 0, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    logic [10:0] op;
    int w;
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(2))
        0: op = 11'h7C2;
        1: op = 11'h7C0;
        default: op = 11'($urandom);
      endcase
      w = ($urandom_range(5) == 0) ? -1 : int'($urandom_range(0, TIMEOUT + 3));
      run_op(mk(op, 9'($urandom), 5'($urandom), 5'($urandom)), w,
             1'($urandom_range(1)), "random");
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mem_ready = 1'b0; IR = 32'd0;
    test_reset();
    test_directed();
    test_reset_mid_mem();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
